// File: rtl/iob_plic_pkg.sv
// iob_plic_pkg: register offsets, width helpers and the "no interrupt" ID shared by the PLIC files.
// Latency: none (declarations only); backpressure: not applicable.
package iob_plic_pkg;

  localparam logic [11:0] CONFIG_OFF  = 12'h000;
  localparam logic [11:0] PRIO_OFF    = 12'h100;
  localparam logic [11:0] PENDING_OFF = 12'h200;
  localparam logic [11:0] ENABLE_OFF  = 12'h300;
  localparam logic [11:0] THRESH_OFF  = 12'h400;
  localparam logic [11:0] CLAIM_OFF   = 12'h500;

  localparam int ID_NONE = 0;

  function automatic int pw_f(input int priorities);
    return (priorities <= 2) ? 1 : $clog2(priorities);
  endfunction

  function automatic int cnt_w_f(input int max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int id_w_f(input int sources);
    return $clog2(sources + 1);
  endfunction

endpackage

// File: rtl/iob_plic_if.sv
// iob_plic_if: IOb native bus request/response bundle between the CPU side and the PLIC.
// Latency: ready one cycle after valid; backpressure: none, slave always accepts.
interface iob_plic_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_plic_target.sv
// iob_plic_target: per-target arbiter, highest priority above threshold wins, lowest ID on ties.
// Latency: best_id combinational, irq registered one cycle; backpressure: none.
module iob_plic_target
  import iob_plic_pkg::*;
#(
  parameter int SOURCES = 8,
  parameter int PW      = 3,
  parameter int IDW     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SOURCES-1:0]         eligible,
  input  logic [SOURCES-1:0][PW-1:0] prio,
  input  logic [SOURCES-1:0]         enable,
  input  logic [PW-1:0]              threshold,
  output logic [IDW-1:0]             best_id,
  output logic                       irq
);

  logic [SOURCES-1:0] cand;
  logic [PW-1:0]      best_prio;

  // Ascending scan with a strict compare keeps the lowest ID among equal priorities.
  always_comb begin
    cand      = '0;
    best_id   = IDW'(ID_NONE);
    best_prio = '0;
    for (int i = 0; i < SOURCES; i++) begin
      cand[i] = eligible[i] & enable[i] & (prio[i] > threshold);
      if (cand[i] && (best_id == IDW'(ID_NONE) || prio[i] > best_prio)) begin
        best_id   = IDW'(i + 1);
        best_prio = prio[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |cand;
  end

endmodule

// File: rtl/iob_plic_core.sv
// iob_plic_core: PLIC with edge gateways, claim/complete and per-target arbitration; IOB_PLIC_PEND_COUNT_EN selects pending counters over pending bits.
// Latency: bus ready/rdata one cycle after valid, irq one cycle after candidate change; backpressure: none.
module iob_plic_core
  import iob_plic_pkg::*;
#(
  parameter int ADDR_W            = 16,
  parameter int DATA_W            = 32,
  parameter int SOURCES           = 8,
  parameter int TARGETS           = 2,
  parameter int PRIORITIES        = 8,
  parameter int MAX_PENDING_COUNT = 8,
  parameter int HAS_THRESHOLD     = 1,
  parameter int HAS_CONFIG_REG    = 1
) (
  input  logic               clk,
  input  logic               rst,
  iob_plic_if.slave          bus,
  input  logic [SOURCES-1:0] src,
  output logic [TARGETS-1:0] irq
);

  localparam int PW = pw_f(PRIORITIES);
`ifdef IOB_PLIC_PEND_COUNT_EN
  localparam int EFF_MAX = MAX_PENDING_COUNT;
`else
  localparam int EFF_MAX = 1;
`endif
  localparam int CW  = cnt_w_f(EFF_MAX);
  localparam int IDW = id_w_f(SOURCES);
  localparam logic [31:0] CFG_WORD = (HAS_CONFIG_REG != 0) ?
    {(HAS_THRESHOLD != 0), 7'(EFF_MAX), 8'(PRIORITIES), 8'(TARGETS), 8'(SOURCES)} : 32'h0;

  logic [SOURCES-1:0][PW-1:0]  prio;
  logic [TARGETS-1:0][SOURCES-1:0] en;
  logic [TARGETS-1:0][PW-1:0]  thr;
  logic [SOURCES-1:0][CW-1:0]  count;
  logic [SOURCES-1:0]          inservice, src_q, rise, pend, eligible, claim_hit, cmp_hit;
  logic [TARGETS-1:0][IDW-1:0] best_id;
  logic [IDW-1:0]              claim_id;
  logic [DATA_W-1:0]           rd_mux;

  logic       hi_zero, rd, wr;
  logic [3:0] pg;
  logic [5:0] idx;
  logic       sel_cfg, sel_prio, sel_pend, sel_en, sel_thr, sel_clm;
  logic       unused_addr;

  assign hi_zero     = (bus.address[ADDR_W-1:12] == '0);
  assign pg          = bus.address[11:8];
  assign idx         = bus.address[7:2];
  assign unused_addr = ^bus.address[1:0];
  assign rd          = bus.valid & ~|bus.wstrb;
  assign wr          = bus.valid & |bus.wstrb;

  assign sel_cfg  = hi_zero && pg == CONFIG_OFF[11:8]  && idx == '0;
  assign sel_prio = hi_zero && pg == PRIO_OFF[11:8]    && 32'(idx) < SOURCES;
  assign sel_pend = hi_zero && pg == PENDING_OFF[11:8] && idx == '0;
  assign sel_en   = hi_zero && pg == ENABLE_OFF[11:8]  && 32'(idx) < TARGETS;
  assign sel_thr  = hi_zero && pg == THRESH_OFF[11:8]  && 32'(idx) < TARGETS;
  assign sel_clm  = hi_zero && pg == CLAIM_OFF[11:8]   && 32'(idx) < TARGETS;

  always_comb begin
    claim_id = IDW'(ID_NONE);
    if (rd && sel_clm)
      for (int t = 0; t < TARGETS; t++)
        if (32'(idx) == t) claim_id = best_id[t];
  end

  always_comb begin
    rise      = src & ~src_q;
    pend      = '0;
    eligible  = '0;
    claim_hit = '0;
    cmp_hit   = '0;
    for (int i = 0; i < SOURCES; i++) begin
      pend[i]      = (count[i] != '0);
      eligible[i]  = pend[i] & ~inservice[i] & (prio[i] != '0);
      claim_hit[i] = (claim_id == IDW'(i + 1));
      cmp_hit[i]   = wr && sel_clm && (bus.wdata == DATA_W'(i + 1)) && inservice[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_cfg) rd_mux = CFG_WORD;
    else if (sel_pend) rd_mux = DATA_W'(pend);
    else if (sel_clm) rd_mux = DATA_W'(claim_id);
    else begin
      for (int i = 0; i < SOURCES; i++)
        if (sel_prio && 32'(idx) == i) rd_mux = DATA_W'(prio[i]);
      for (int t = 0; t < TARGETS; t++) begin
        if (sel_en && 32'(idx) == t)  rd_mux = DATA_W'(en[t]);
        if (sel_thr && 32'(idx) == t) rd_mux = DATA_W'(thr[t]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      prio      <= '0;
      en        <= '0;
      thr       <= '0;
      count     <= '0;
      inservice <= '0;
      src_q     <= '0;
    end else begin
      bus.ready <= bus.valid;
      bus.rdata <= rd ? rd_mux : '0;
      src_q     <= src;
      if (wr) begin
        for (int i = 0; i < SOURCES; i++)
          if (sel_prio && 32'(idx) == i) prio[i] <= bus.wdata[PW-1:0];
        for (int t = 0; t < TARGETS; t++) begin
          if (sel_en && 32'(idx) == t) en[t] <= bus.wdata[SOURCES-1:0];
          if (HAS_THRESHOLD != 0 && sel_thr && 32'(idx) == t) thr[t] <= bus.wdata[PW-1:0];
        end
      end
      for (int i = 0; i < SOURCES; i++) begin
        if (claim_hit[i])    inservice[i] <= 1'b1;
        else if (cmp_hit[i]) inservice[i] <= 1'b0;
        // Edge and claim in the same cycle cancel, which also holds a saturated count.
        if (rise[i] && !claim_hit[i]) begin
          if (count[i] != CW'(EFF_MAX)) count[i] <= count[i] + 1'b1;
        end else if (claim_hit[i] && !rise[i]) begin
          count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

  for (genvar t = 0; t < TARGETS; t++) begin : g_tgt
    iob_plic_target #(
      .SOURCES (SOURCES),
      .PW      (PW),
      .IDW     (IDW)
    ) u_tgt (
      .clk       (clk),
      .rst       (rst),
      .eligible  (eligible),
      .prio      (prio),
      .enable    (en[t]),
      .threshold (thr[t]),
      .best_id   (best_id[t]),
      .irq       (irq[t])
    );
  end

endmodule

// File: tb/tb_iob_plic_core.sv
// tb_iob_plic_core: directed and random claim/complete traffic against an array-based PLIC model.
// Latency: bus transfers take two cycles each; backpressure: none.
module tb_iob_plic_core;
  import iob_plic_pkg::*;

  localparam int S = 8;
  localparam int T = 2;
`ifdef IOB_PLIC_PEND_COUNT_EN
  localparam int MAXM = 8;
  localparam int EXP_REPS = 3;
`else
  localparam int MAXM = 1;
  localparam int EXP_REPS = 1;
`endif
  localparam logic [31:0] EXP_CFG = {1'b1, 7'(MAXM), 8'd8, 8'd2, 8'd8};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [S-1:0] src = '0;
  logic [T-1:0] irq;

  iob_plic_if #(.ADDR_W(16), .DATA_W(32)) bif ();

  iob_plic_core u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif),
    .src (src),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int prio_m [1:S];
  int cnt_m  [1:S];
  bit ins_m  [1:S];
  bit [31:0] en_m [T];
  int thr_m [T];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 1; id <= S; id++) begin
      prio_m[id] = 0; cnt_m[id] = 0; ins_m[id] = 0;
    end
    for (int t = 0; t < T; t++) begin
      en_m[t] = 0; thr_m[t] = 0;
    end
  endtask

  function automatic int model_best(input int t);
    int b  = 0;
    int bp = 0;
    for (int id = 1; id <= S; id++)
      if (cnt_m[id] > 0 && !ins_m[id] && en_m[t][id-1] && prio_m[id] > thr_m[t] && prio_m[id] > bp) begin
        b = id; bp = prio_m[id];
      end
    return b;
  endfunction

  function automatic logic [31:0] model_irq();
    logic [31:0] v = '0;
    for (int t = 0; t < T; t++) v[t] = (model_best(t) != 0);
    return v;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] v = '0;
    for (int id = 1; id <= S; id++) v[id-1] = (cnt_m[id] > 0);
    return v;
  endfunction

  task automatic model_step(input int claim_id, input int pulse_id);
    for (int id = 1; id <= S; id++) begin
      if (pulse_id == id && claim_id != id) cnt_m[id] = (cnt_m[id] < MAXM) ? cnt_m[id] + 1 : MAXM;
      else if (claim_id == id && pulse_id != id) cnt_m[id] = cnt_m[id] - 1;
    end
    if (claim_id > 0) ins_m[claim_id] = 1;
  endtask

  // One bus access; optionally raises src[pulse_id-1] in the request cycle.
  task automatic xfer(input int a, input logic [31:0] d, input logic [3:0] s,
                      input int pulse_id, output logic [31:0] r);
    @(negedge clk);
    bif.valid = 1'b1; bif.address = 16'(a); bif.wdata = d; bif.wstrb = s;
    if (pulse_id > 0) src[pulse_id-1] = 1'b1;
    @(posedge clk); #1;
    chk("ready_hi", 32'(bif.ready), 32'd1);
    r = bif.rdata;
    bif.valid = 1'b0; bif.wstrb = '0;
    if (pulse_id > 0) src[pulse_id-1] = 1'b0;
    @(posedge clk); #1;
    chk("ready_lo", 32'(bif.ready), 32'd0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    logic [31:0] r;
    xfer(a, d, 4'hF, 0, r);
  endtask

  task automatic rd(input int a, output logic [31:0] r);
    xfer(a, 32'h0, 4'h0, 0, r);
  endtask

  task automatic pulse(input int id);
    @(negedge clk); src[id-1] = 1'b1;
    @(negedge clk); src[id-1] = 1'b0;
    model_step(0, id);
  endtask

  task automatic claim(input int t, input int pulse_id, input string tag, output int got);
    logic [31:0] r;
    int exp_id;
    exp_id = model_best(t);
    xfer(int'(CLAIM_OFF) + 4*t, 32'h0, 4'h0, pulse_id, r);
    chk(tag, r, 32'(exp_id));
    model_step(exp_id, pulse_id);
    got = int'(r);
  endtask

  task automatic complete(input int t, input int id);
    wr(int'(CLAIM_OFF) + 4*t, 32'(id));
    if (id >= 1 && id <= S && ins_m[id]) ins_m[id] = 0;
  endtask

  task automatic settle_check(input string tag);
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_irq"}, 32'(irq), model_irq());
    rd(int'(PENDING_OFF), r);
    chk({tag, "_pend"}, r, model_pend());
  endtask

  logic [31:0] r, v;
  int got, reps, id, t, op;

  initial begin
    bif.valid = 1'b0; bif.address = '0; bif.wdata = '0; bif.wstrb = '0;
    model_reset();

    // Reset state
    #3;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ready", 32'(bif.ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(int'(CONFIG_OFF), r);
    chk("config", r, EXP_CFG);
    rd(int'(PENDING_OFF), r);
    chk("rst_pend", r, 32'd0);

    // Single source to target 0
    wr(int'(PRIO_OFF) + 4*2, 32'd5);   prio_m[3] = 5;
    wr(int'(ENABLE_OFF), 32'h04);      en_m[0] = 32'h04;
    wr(int'(THRESH_OFF), 32'd0);       thr_m[0] = 0;
    pulse(3);
    settle_check("single");
    chk("single_irq_const", 32'(irq), 32'd1);
    claim(0, 0, "single_claim", got);
    chk("single_claim_id", 32'(got), 32'd3);
    settle_check("after_claim");
    complete(0, 3);
    settle_check("after_complete");
    chk("complete_irq_const", 32'(irq), 32'd0);

    // Priority ordering and tie-break
    wr(int'(PRIO_OFF) + 4*1, 32'd4);   prio_m[2] = 4;
    wr(int'(PRIO_OFF) + 4*4, 32'd4);   prio_m[5] = 4;
    wr(int'(PRIO_OFF) + 4*6, 32'd6);   prio_m[7] = 6;
    wr(int'(ENABLE_OFF), 32'h52);      en_m[0] = 32'h52;
    pulse(2); pulse(5); pulse(7);
    settle_check("tie_setup");
    claim(0, 0, "tie_c1", got); chk("tie_first", 32'(got), 32'd7);
    claim(0, 0, "tie_c2", got); chk("tie_second", 32'(got), 32'd2);
    claim(0, 0, "tie_c3", got); chk("tie_third", 32'(got), 32'd5);
    claim(0, 0, "tie_c4", got); chk("tie_empty", 32'(got), 32'd0);
    complete(0, 7); complete(0, 2); complete(0, 5);
    settle_check("tie_done");

    // Threshold gating
    wr(int'(PRIO_OFF), 32'd5);         prio_m[1] = 5;
    wr(int'(ENABLE_OFF) + 4, 32'h01);  en_m[1] = 32'h01;
    wr(int'(THRESH_OFF) + 4, 32'd5);   thr_m[1] = 5;
    pulse(1);
    settle_check("thr_block");
    chk("thr_block_irq1", 32'(irq[1]), 32'd0);
    wr(int'(THRESH_OFF) + 4, 32'd4);   thr_m[1] = 4;
    chk("thr_open_irq1", 32'(irq[1]), 32'd1);

    // Pending count with edges while in service
    claim(1, 0, "cnt_first", got);
    chk("cnt_first_id", 32'(got), 32'd1);
    pulse(1); pulse(1); pulse(1);
    complete(1, 1);
    reps = 0;
    for (int k = 0; k < 4; k++) begin
      claim(1, 0, "cnt_loop", got);
      if (got == 1) begin
        reps++;
        complete(1, 1);
      end
    end
    chk("cnt_reps", 32'(reps), 32'(EXP_REPS));
    claim(1, 0, "cnt_final", got);
    chk("cnt_final_id", 32'(got), 32'd0);

    // Simultaneous edge and claim on the same source
    pulse(1);
    claim(1, 1, "edge_claim", got);
    settle_check("edge_claim");
    complete(1, 1);
    settle_check("edge_claim_done");

    // Bus edge cases
    rd(16'h0FF0, r);
    chk("unmapped_rd", r, 32'd0);
    wr(16'h0FF0, 32'hFFFF_FFFF);
    rd(int'(PRIO_OFF) + 4*S, r);
    chk("prio_oob", r, 32'd0);
    wr(int'(CONFIG_OFF), 32'h0);
    rd(int'(CONFIG_OFF), r);
    chk("config_ro", r, EXP_CFG);
    pulse(3);
    wr(int'(ENABLE_OFF), 32'h56);      en_m[0] = 32'h56;
    complete(0, 9);
    complete(0, 3);
    settle_check("bad_complete");
    chk("bad_complete_irq0", 32'(irq[0]), 32'd1);

    // Reset mid-run
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_irq", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    settle_check("mid_rst");
    rd(int'(PRIO_OFF) + 4*2, r);
    chk("mid_rst_prio", r, 32'd0);
    rd(int'(ENABLE_OFF), r);
    chk("mid_rst_en", r, 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1: pulse($urandom_range(1, S));
        2: begin
          id = $urandom_range(1, S); v = $urandom;
          wr(int'(PRIO_OFF) + 4*(id-1), v); prio_m[id] = int'(v[2:0]);
        end
        3: begin
          t = $urandom_range(0, T-1); v = $urandom;
          wr(int'(ENABLE_OFF) + 4*t, v); en_m[t] = {24'h0, v[7:0]};
        end
        4: begin
          t = $urandom_range(0, T-1); v = $urandom;
          wr(int'(THRESH_OFF) + 4*t, v); thr_m[t] = int'(v[2:0]);
        end
        5: claim($urandom_range(0, T-1),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S)) : 0, "rand_claim", got);
        6: complete($urandom_range(0, T-1), $urandom_range(0, 10));
        default: begin
          id = $urandom_range(1, S); t = $urandom_range(0, T-1);
          rd(int'(PRIO_OFF) + 4*(id-1), r);   chk("rand_prio_rd", r, 32'(prio_m[id]));
          rd(int'(ENABLE_OFF) + 4*t, r);      chk("rand_en_rd", r, en_m[t]);
          rd(int'(THRESH_OFF) + 4*t, r);      chk("rand_thr_rd", r, 32'(thr_m[t]));
        end
      endcase
      if (k % 8 == 7) settle_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
